// File: rtl/or_force_combiner.sv
// OR-combiner of NCH channels with a registered output, a timed/held override
// path and a saturating counter of zero-to-nonzero output transitions.
module or_force_combiner #(
  parameter int NCH   = 2,
  parameter int WIDTH = 1,
  parameter int LEN_W = 8,
  parameter int EVT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic                   force_req,
  input  logic [WIDTH-1:0]       force_val,
  input  logic [LEN_W-1:0]       force_len,
  input  logic                   release_req,
  output logic [WIDTH-1:0]       out_data,
  output logic                   forcing,
  output logic [LEN_W-1:0]       force_left,
  output logic [EVT_W-1:0]       rise_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TIMED = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] ovr_val;
  logic [WIDTH-1:0] ovr_val_nxt;
  logic [WIDTH-1:0] or_all;
  logic [WIDTH-1:0] out_nxt;
  logic [LEN_W-1:0] left_nxt;
  logic             rise;

  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (&v) ? v : v + EVT_W'(1);
  endfunction

  always_comb begin
    or_all = '0;
    for (int i = 0; i < NCH; i++) begin
      or_all = or_all | in_data[i*WIDTH +: WIDTH];
    end
  end

  // Release wins over force; a force re-arms from any state.
  always_comb begin
    state_nxt   = state;
    ovr_val_nxt = ovr_val;
    left_nxt    = force_left;
    if (release_req) begin
      state_nxt = IDLE;
      left_nxt  = '0;
    end else if (force_req) begin
      ovr_val_nxt = force_val;
      if (force_len != '0) begin
        state_nxt = TIMED;
        left_nxt  = force_len;
      end else begin
        state_nxt = HOLD;
        left_nxt  = '0;
      end
    end else begin
      case (state)
        TIMED: begin
          if (force_left > LEN_W'(1)) begin
            left_nxt = force_left - LEN_W'(1);
          end else begin
            state_nxt = IDLE;
            left_nxt  = '0;
          end
        end
        HOLD: begin
          state_nxt = HOLD;
        end
        default: begin
          state_nxt = IDLE;
          left_nxt  = '0;
        end
      endcase
    end
    out_nxt = (state_nxt == IDLE) ? or_all : ovr_val_nxt;
    rise    = (out_data == '0) && (out_nxt != '0);
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ovr_val    <= '0;
      out_data   <= '0;
      force_left <= '0;
      rise_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      ovr_val    <= ovr_val_nxt;
      out_data   <= out_nxt;
      force_left <= left_nxt;
      if (rise) begin
        rise_cnt <= sat_inc(rise_cnt);
      end
    end
  end

  assign forcing = (state == TIMED) || (state == HOLD);

endmodule
